// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the pipelined CORDIC engine: mode enum,
// arctangent table, gain constant and quarter-turn angle.
package cordic_pkg;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  // atan(2^-i) as a 32-bit binary angle (2^32 = one full turn).
  function automatic logic [31:0] atan32(input int i);
    case (i)
      0:  return 32'h20000000;
      1:  return 32'h12E4051E;
      2:  return 32'h09FB385B;
      3:  return 32'h051111D4;
      4:  return 32'h028B0D43;
      5:  return 32'h0145D7E1;
      6:  return 32'h00A2F61E;
      7:  return 32'h00517C55;
      8:  return 32'h0028BE53;
      9:  return 32'h00145F2F;
      10: return 32'h000A2F98;
      11: return 32'h000517CC;
      12: return 32'h00028BE6;
      13: return 32'h000145F3;
      14: return 32'h0000A2FA;
      15: return 32'h0000517D;
      16: return 32'h000028BE;
      17: return 32'h0000145F;
      18: return 32'h00000A30;
      19: return 32'h00000518;
      20: return 32'h0000028C;
      21: return 32'h00000146;
      22: return 32'h000000A3;
      23: return 32'h00000051;
      24: return 32'h00000029;
      25: return 32'h00000014;
      26: return 32'h0000000A;
      27: return 32'h00000005;
      28: return 32'h00000003;
      29: return 32'h00000001;
      default: return 32'h00000000;
    endcase
  endfunction

  // Rounded arctangent for stage i at an angle width of aw bits.
  function automatic logic [31:0] atan_val(input int i, input int aw);
    logic [63:0] v;
    v = {32'd0, atan32(i)} + (64'd1 << (31 - aw));
    v = v >> (32 - aw);
    return v[31:0];
  endfunction

  // round(0.6072529 * 2^(w-1)), derived from a 32-bit fraction of K.
  function automatic logic [31:0] k_q(input int w);
    logic [63:0] v;
    v = 64'd2608131496 + (64'd1 << (32 - w));
    v = v >> (33 - w);
    return v[31:0];
  endfunction

  function automatic logic [31:0] quarter_turn(input int aw);
    return 32'd1 << (aw - 2);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation register stage with shift index I; sideband
// (valid, mode, tag) is registered alongside the data.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XW = 18,
  parameter int AW = 16,
  parameter int TAG_W = 4,
  parameter int I = 0,
  parameter logic [AW-1:0] ATAN = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_d,
  input  logic                 mode_d,
  input  logic signed [XW-1:0] x_d,
  input  logic signed [XW-1:0] y_d,
  input  logic [AW-1:0]        z_d,
  input  logic [TAG_W-1:0]     tag_d,
  output logic                 valid_q,
  output logic                 mode_q,
  output logic signed [XW-1:0] x_q,
  output logic signed [XW-1:0] y_q,
  output logic [AW-1:0]        z_q,
  output logic [TAG_W-1:0]     tag_q
);

  logic                 d_pos;
  logic signed [XW-1:0] x_sh, y_sh, x_nx, y_nx;
  logic [AW-1:0]        z_nx;

  always_comb begin
    // Vectoring drives y to zero, rotation drives z to zero.
    d_pos = (mode_e'(mode_d) == MODE_VEC) ? y_d[XW-1] : ~z_d[AW-1];
    x_sh  = x_d >>> I;
    y_sh  = y_d >>> I;
    if (d_pos) begin
      x_nx = x_d - y_sh;
      y_nx = y_d + x_sh;
      z_nx = z_d - ATAN;
    end else begin
      x_nx = x_d + y_sh;
      y_nx = y_d - x_sh;
      z_nx = z_d + ATAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      tag_q   <= '0;
    end else if (en) begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      x_q     <= x_nx;
      y_q     <= y_nx;
      z_q     <= z_nx;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC: quadrant pre-rotation, STAGES micro-rotations and
// a gain/saturation stage, all stalled together by a single advance enable.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int W = 16,
  parameter int AW = 16,
  parameter int STAGES = 14,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [W-1:0]     x_in,
  input  logic [W-1:0]     y_in,
  input  logic [AW-1:0]    z_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     x_out,
  output logic [W-1:0]     y_out,
  output logic [AW-1:0]    z_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             mode_out
);

  localparam int XW = W + 2;
  localparam int PW = XW + W + 1;
  localparam logic [31:0] QT32 = quarter_turn(AW);
  localparam logic [AW-1:0] QT = QT32[AW-1:0];
  localparam logic [31:0] KQ32 = k_q(W);
  localparam logic signed [PW-1:0] KQ = {{(PW-W){1'b0}}, KQ32[W-1:0]};

  // Handshake: a sample moves into the pipe when in_valid & in_ready; a
  // result leaves when out_valid & out_ready. The whole pipe moves only on
  // advance, so a stalled result holds every register, valid bits included.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  logic signed [XW-1:0] xe, ye, pr_x, pr_y;
  logic [AW-1:0]        pr_z;
  assign xe = {{2{x_in[W-1]}}, x_in};
  assign ye = {{2{y_in[W-1]}}, y_in};

  always_comb begin
    pr_x = xe;
    pr_y = ye;
    pr_z = z_in;
    if (mode_e'(in_mode) == MODE_ROT) begin
      case (z_in[AW-1:AW-2])
        2'b01: begin pr_x = -ye; pr_y = xe;  pr_z = z_in - QT; end
        2'b10: begin pr_x = ye;  pr_y = -xe; pr_z = z_in + QT; end
        default: ;
      endcase
    end else if (x_in[W-1]) begin
      if (!y_in[W-1]) begin
        pr_x = ye;  pr_y = -xe; pr_z = z_in + QT;
      end else begin
        pr_x = -ye; pr_y = xe;  pr_z = z_in - QT;
      end
    end
  end

  logic                 p_valid, p_mode;
  logic signed [XW-1:0] p_x, p_y;
  logic [AW-1:0]        p_z;
  logic [TAG_W-1:0]     p_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid <= 1'b0;
      p_mode  <= 1'b0;
      p_x     <= '0;
      p_y     <= '0;
      p_z     <= '0;
      p_tag   <= '0;
    end else if (advance) begin
      p_valid <= in_valid;
      p_mode  <= in_mode;
      p_x     <= pr_x;
      p_y     <= pr_y;
      p_z     <= pr_z;
      p_tag   <= tag_in;
    end
  end

  logic                 c_valid [0:STAGES];
  logic                 c_mode  [0:STAGES];
  logic signed [XW-1:0] c_x     [0:STAGES];
  logic signed [XW-1:0] c_y     [0:STAGES];
  logic [AW-1:0]        c_z     [0:STAGES];
  logic [TAG_W-1:0]     c_tag   [0:STAGES];

  assign c_valid[0] = p_valid;
  assign c_mode[0]  = p_mode;
  assign c_x[0]     = p_x;
  assign c_y[0]     = p_y;
  assign c_z[0]     = p_z;
  assign c_tag[0]   = p_tag;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam logic [31:0] A32 = atan_val(g, AW);
    cordic_stage #(
      .XW(XW), .AW(AW), .TAG_W(TAG_W), .I(g), .ATAN(A32[AW-1:0])
    ) u_stage (
      .clk(clk), .rst(rst), .en(advance),
      .valid_d(c_valid[g]), .mode_d(c_mode[g]),
      .x_d(c_x[g]), .y_d(c_y[g]), .z_d(c_z[g]), .tag_d(c_tag[g]),
      .valid_q(c_valid[g+1]), .mode_q(c_mode[g+1]),
      .x_q(c_x[g+1]), .y_q(c_y[g+1]), .z_q(c_z[g+1]), .tag_q(c_tag[g+1])
    );
  end

  function automatic logic [W-1:0] sat(input logic signed [PW-1:0] v);
    if (v[PW-1:W-1] == {(PW-W+1){v[PW-1]}}) return v[W-1:0];
    return v[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  logic signed [PW-1:0] xm, ym, gx, gy;
  always_comb begin
    xm = PW'(c_x[STAGES]);
    ym = PW'(c_y[STAGES]);
    gx = (xm * KQ) >>> (W - 1);
    gy = (ym * KQ) >>> (W - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      mode_out  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      tag_out   <= '0;
    end else if (advance) begin
      out_valid <= c_valid[STAGES];
      mode_out  <= c_mode[STAGES];
      x_out     <= sat(gx);
      y_out     <= sat(gy);
      z_out     <= c_z[STAGES];
      tag_out   <= c_tag[STAGES];
    end
  end

endmodule

// File: tb/tb_cordic_pipe.sv
// Bench for cordic_pipe: directed vector table with tolerances, a bit-exact
// reference model feeding a scoreboard, backpressure and mid-stream reset.
module tb_cordic_pipe;
  import cordic_pkg::*;

  localparam int W = 16;
  localparam int AW = 16;
  localparam int STAGES = 14;
  localparam int TAG_W = 4;
  localparam int LAT = STAGES + 2;

  logic             clk, rst;
  logic             in_valid, in_ready, in_mode;
  logic [W-1:0]     x_in, y_in, x_out, y_out;
  logic [AW-1:0]    z_in, z_out;
  logic [TAG_W-1:0] tag_in, tag_out;
  logic             out_valid, out_ready, mode_out;

  cordic_pipe #(.W(W), .AW(AW), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .tag_out(tag_out), .mode_out(mode_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [W-1:0]     x;
    logic [W-1:0]     y;
    logic [AW-1:0]    z;
    logic [TAG_W-1:0] tag;
    logic             mode;
  } res_t;

  res_t exp_q[$];
  int   acc_q[$];
  int   n_chk = 0, n_pass = 0, n_out = 0, last_lat = 0;
  res_t last_got, held, got, expv;
  bit   hold_v = 0, bp_en = 0;
  int   acc;
  int   atan_tab[STAGES];

  function automatic logic [W-1:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return v[15:0];
  endfunction

  // reference model built directly from the algorithm description
  function automatic res_t model(input logic mode, input logic [W-1:0] x, y,
                                 input logic [AW-1:0] z, input logic [TAG_W-1:0] tag);
    longint xi, yi, xt;
    logic [AW-1:0] zi;
    bit dpos;
    res_t r;
    xi = longint'($signed(x));
    yi = longint'($signed(y));
    zi = z;
    if (mode == 1'b0) begin
      if (zi[AW-1:AW-2] == 2'b01) begin
        xt = xi; xi = -yi; yi = xt; zi = zi - 16'h4000;
      end else if (zi[AW-1:AW-2] == 2'b10) begin
        xt = xi; xi = yi; yi = -xt; zi = zi + 16'h4000;
      end
    end else if (xi < 0) begin
      if (yi >= 0) begin
        xt = xi; xi = yi; yi = -xt; zi = zi + 16'h4000;
      end else begin
        xt = xi; xi = -yi; yi = xt; zi = zi - 16'h4000;
      end
    end
    for (int i = 0; i < STAGES; i++) begin
      dpos = mode ? (yi < 0) : !zi[AW-1];
      xt = xi;
      if (dpos) begin
        xi = xi - (yi >>> i); yi = yi + (xt >>> i); zi = zi - 16'(atan_tab[i]);
      end else begin
        xi = xi + (yi >>> i); yi = yi - (xt >>> i); zi = zi + 16'(atan_tab[i]);
      end
    end
    r.x = sat16((xi * 19898) >>> 15);
    r.y = sat16((yi * 19898) >>> 15);
    r.z = zi;
    r.tag = tag;
    r.mode = mode;
    return r;
  endfunction

  task automatic check_rng(input string name, input longint got_v, input longint exp_v,
                           input longint tol);
    n_chk++;
    if (got_v >= exp_v - tol && got_v <= exp_v + tol) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (tol %0d)", name, got_v, exp_v, tol);
  endtask

  function automatic longint zdiff(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW-1:0] d;
    d = a - b;
    return longint'($signed(d));
  endfunction

  // scoreboard / monitor: transfers and stalls are judged just before the edge
  always @(negedge clk) begin
    got = {x_out, y_out, z_out, tag_out, mode_out};
    if (hold_v) begin
      hold_v = 0;
      n_chk++;
      if (out_valid === 1'b1 && got === held) n_pass++;
      else $display("FAIL stall_hold: got %h valid %b, want %h held", got, out_valid, held);
    end
    if (!rst && out_valid === 1'b1) begin
      if (out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_out: got %h with nothing pending", got);
        end else begin
          expv = exp_q.pop_front();
          acc = acc_q.pop_front();
          last_lat = cyc - acc;
          if (got === expv) n_pass++;
          else $display("FAIL model_match: got %h, want %h", got, expv);
        end
        last_got = got;
        n_out++;
      end else begin
        hold_v = 1;
        held = got;
      end
    end
  end

  // downstream ready: random while bp_en, otherwise always ready
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // driver: holds the sample until accepted, then pushes the expectation
  task automatic send(input logic mode, input logic [W-1:0] x, y,
                      input logic [AW-1:0] z, input logic [TAG_W-1:0] tag);
    bit ok;
    ok = 0;
    in_valid = 1'b1; in_mode = mode; x_in = x; y_in = y; z_in = z; tag_in = tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready && !rst) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stuck low for tag %0d", tag);
    end else begin
      exp_q.push_back(model(mode, x, y, z, tag));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int start);
    bit ok;
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (n_out > start) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL out_timeout: no result within 100 cycles, got %0d outputs", n_out);
    end
    #1;
  endtask

  typedef struct {
    logic  mode;
    int    x, y, z;
    int    ex, ey, ez;
    int    txy;
    bit    chk_y;
    string name;
  } vec_t;

  vec_t vt[7];
  int s;

  initial begin
    for (int i = 0; i < STAGES; i++)
      atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 65536.0 / (2.0 * 3.14159265358979) + 0.5);

    vt[0] = '{MODE_ROT, 16384, 0, 'h2000, 11585, 11585, 0, 4, 1'b1, "rot45"};
    vt[1] = '{MODE_ROT, 16384, 0, 'h6000, -11585, 11585, 0, 4, 1'b1, "rot135"};
    vt[2] = '{MODE_ROT, 16384, 0, 'h8000, -16384, 0, 0, 4, 1'b1, "rot180"};
    vt[3] = '{MODE_VEC, 10000, 10000, 0, 14142, 0, 'h2000, 6, 1'b0, "vec_q1"};
    vt[4] = '{MODE_VEC, -10000, 0, 0, 10000, 0, 'h8000, 6, 1'b0, "vec_negx"};
    vt[5] = '{MODE_VEC, -10000, -1, 0, 10000, 0, 'h8000, 6, 1'b0, "vec_negx_ym1"};
    vt[6] = '{MODE_VEC, 32767, 32767, 0, 32767, 0, 'h2000, 0, 1'b0, "vec_sat"};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_rng("rst_out_valid", out_valid, 0, 0);
    check_rng("rst_in_ready", in_ready, 1, 0);
    check_rng("rst_outputs", {x_out, y_out, z_out, tag_out, mode_out}, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed vectors, one at a time
    for (int i = 0; i < 7; i++) begin
      s = n_out;
      send(vt[i].mode, 16'(vt[i].x), 16'(vt[i].y), 16'(vt[i].z), 4'(i));
      in_valid = 1'b0;
      wait_out(s);
      check_rng({vt[i].name, "_x"}, $signed(last_got.x), vt[i].ex, vt[i].txy);
      if (vt[i].chk_y) check_rng({vt[i].name, "_y"}, $signed(last_got.y), vt[i].ey, vt[i].txy);
      check_rng({vt[i].name, "_z_err"}, zdiff(last_got.z, 16'(vt[i].ez)), 0, 8);
      check_rng({vt[i].name, "_latency"}, last_lat, LAT, 0);
    end

    // backpressure stream, alternating modes, random bubbles
    bp_en = 1;
    s = n_out;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(1'(i % 2), 16'($urandom), 16'($urandom), 16'($urandom), 4'(i));
    end
    in_valid = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    bp_en = 0;
    #1;
    check_rng("bp_result_count", n_out - s, 40, 0);
    check_rng("bp_pending", exp_q.size(), 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // reset with 10 samples in flight and a sample offered during reset
    for (int i = 0; i < 10; i++)
      send(1'(i % 2), 16'($urandom), 16'($urandom), 16'($urandom), 4'(i));
    rst = 1'b1;
    in_valid = 1'b1; in_mode = 1'b0; x_in = 16'd1234; y_in = '0; z_in = '0; tag_in = 4'hF;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    check_rng("midrst_out_valid", out_valid, 0, 0);
    check_rng("midrst_in_ready", in_ready, 1, 0);
    check_rng("midrst_outputs", {x_out, y_out, z_out, tag_out, mode_out}, 0, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    s = n_out;
    repeat (30) @(posedge clk);
    #1;
    check_rng("midrst_no_stale", n_out - s, 0, 0);
    s = n_out;
    send(MODE_ROT, 16'd16384, 16'd0, 16'h2000, 4'h5);
    in_valid = 1'b0;
    wait_out(s);
    check_rng("midrst_new_latency", last_lat, LAT, 0);
    check_rng("midrst_new_x", $signed(last_got.x), 11585, 4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_pipe.md
# cordic_pipe

Parametrised, fully pipelined CORDIC engine with run-time mode selection per sample. Rotation mode rotates (x, y) by z; vectoring mode produces magnitude and phase of (x, y). Width, stage count and angle resolution are set by parameters. Quadrant pre-rotation gives full ±180° coverage, gain compensation is built in, and a valid/ready handshake with global stall lets it sit between the sample front-end and downstream DSP.

## Interface
- `W`, 16: x/y sample width, signed two's complement (Q1.(W-1)).
- `AW`, 16: angle width; binary angle, full scale 2^AW = 360°, so 0x2000 = 45° and 0x8000 = -180° at AW=16.
- `STAGES`, 14: micro-rotation stages, i = 0..STAGES-1; legal range 4..AW-2.
- `TAG_W`, 4: sideband tag width, carried alongside each sample.
- `clk` in 1: clock; all state changes on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: engine accepts the sample this cycle.
- `in_mode` in 1: 0 = rotation, 1 = vectoring.
- `x_in`, `y_in` in W: input vector.
- `z_in` in AW: rotation angle in rotation mode; phase offset added to the result in vectoring mode.
- `tag_in` in TAG_W: passed through unchanged.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `x_out`, `y_out` out W: gain-compensated, saturated result.
- `z_out` out AW: residual angle in rotation mode; accumulated phase in vectoring mode.
- `tag_out`, `mode_out` out TAG_W/1: sideband aligned with the result.

## Operation
- **Internal width:** x/y use W+2 bits (two guard bits); z uses AW bits and wraps modulo 2^AW by design.
- **Stage P (pre-rotation)** handles the input quadrant:
  - Rotation mode, z[AW-1:AW-2]=01: x'=-y, y'=x, z'=z-0x4000.
  - Rotation mode, z[AW-1:AW-2]=10: x'=y, y'=-x, z'=z+0x4000.
  - Vectoring mode, x<0 and y≥0: x'=y, y'=-x, z'=z+0x4000.
  - Vectoring mode, x<0 and y<0: x'=-y, y'=x, z'=z-0x4000.
  - All other cases pass through unchanged. Constants are scaled for AW.
- **Stage i direction:** rotation mode uses d=+1 if z≥0, else -1. Vectoring mode uses d=+1 if y<0, else -1.
- **Stage i update:**
  - x' = x - d·(y>>>i)
  - y' = y + d·(x>>>i)
  - z' = z - d·ATAN[i]
  - ATAN[i] = round(atan(2^-i)·2^AW/2π).
- **Stage G (gain):**
  - x_out = sat_W((x·K_Q) >>> (W-1)), same for y.
  - K_Q = round(0.6072529·2^(W-1)); 19898 at W=16.
  - Saturation clamps to [-2^(W-1), 2^(W-1)-1].
  - z_out is not scaled.
- Mode, tag and valid travel with each sample, so mixed-mode streams are legal back to back.

## Timing
- Latency is STAGES+2 cycles from acceptance to out_valid, with no stalls. Throughput is 1 sample/cycle.
- advance = ~out_valid | out_ready; in_ready = advance.
- When advance=0, every pipeline register, including valid bits, holds its value. Outputs stay stable while out_valid=1 and out_ready=0.
- A sample is accepted when in_valid & in_ready.
- A bubble (in_valid=0) propagates as valid=0. Downstream bubbles are not collapsed.
- **Reset:**
  - All valid bits clear; out_valid=0, in_ready=1.
  - x_out, y_out, z_out, tag_out and mode_out are all 0.
  - Reset asserted mid-stream discards every in-flight sample. No partial result ever appears.
- Simultaneous rst and in_valid: rst wins and the sample is dropped.

## Structure
- Package `cordic_pkg` holds:
  - the ATAN table function (generated for AW and STAGES);
  - the K_Q function;
  - the quarter-turn constant;
  - the mode enum (MODE_ROT, MODE_VEC).
- Sub-module `cordic_stage`, parametrised by shift index i, implements one micro-rotation register stage including valid/mode/tag. The top level instantiates it STAGES times in a generate loop, plus the pre-rotation and gain stages.

## Test plan
All scenarios use default parameters and out_ready=1 unless stated.
- **Rotation, 45°:** x=16384, y=0, z=0x2000 → x_out, y_out = 11585±4; |z_out| ≤ 8; out_valid exactly 16 cycles after acceptance.
- **Vectoring, first quadrant:** x=y=10000, z=0 → x_out = 14142±6; z_out = 0x2000±8.
- **Vectoring, negative real axis:** x=-10000, y=0 → x_out = 10000±6; z_out = 0x8000±8. Repeat with y=-1 → z_out ≈ 0x8000 (−180°, within ±8).
- **Saturation:** vectoring x=y=32767 → x_out = 32767.
- **Backpressure:**
  - Stream 40 alternating-mode samples while out_ready toggles pseudo-randomly.
  - Every result must match the model, in order, with tags intact.
  - No result may be lost or duplicated, and outputs must hold while stalled.
- **Reset mid-stream:** assert rst for 1 cycle with 10 samples in flight → out_valid=0 and all outputs 0 on the next cycle. No stale result ever appears. The first new sample emerges 16 cycles after acceptance.
